dtlb_pipe: RTL and testbench

DTLB_PIPE -- requirements
Module: dtlb_pipe

---
 rtl/tlb_pkg.sv | 41 ++++
 rtl/utlb_cam.sv | 87 ++++++++
 rtl/dtlb_pipe.sv | 143 ++++++++++++++
 tb/tb_dtlb_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared constants for the data-side micro-TLB pipeline: segments, exception
// bit positions, cache attribute codes and FSM state encoding.
package tlb_pkg;

  localparam logic [2:0] KSEG0      = 3'b100;
  localparam logic [2:0] KSEG1      = 3'b101;
  localparam logic [2:0] C_UNCACHED = 3'd2;

  localparam int EXC_W          = 5;
  localparam int EXC_RD_REFILL  = 0;
  localparam int EXC_WR_REFILL  = 1;
  localparam int EXC_RD_INVALID = 2;
  localparam int EXC_WR_INVALID = 3;
  localparam int EXC_MODIFIED   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOK   = 2'd1,
    ST_REFILL = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Loads take priority when both qualifiers are set, keeping the code one-hot.
  function automatic logic [EXC_W-1:0] map_exc(input logic found, input logic v,
                                               input logic d, input logic rd,
                                               input logic wr);
    logic [EXC_W-1:0] e;
    e = '0;
    if (!found) begin
      if (rd)      e[EXC_RD_REFILL] = 1'b1;
      else if (wr) e[EXC_WR_REFILL] = 1'b1;
    end else if (!v) begin
      if (rd)      e[EXC_RD_INVALID] = 1'b1;
      else if (wr) e[EXC_WR_INVALID] = 1'b1;
    end else if (!d && wr) begin
      e[EXC_MODIFIED] = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/utlb_cam.sv
// Fully associative micro-TLB storage: combinational match, round-robin
// write port and a single-cycle flush that beats a same-cycle write.
module utlb_cam #(
  parameter int N      = 4,
  parameter int ASID_W = 8,
  parameter int PFN_W  = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [19:0]       look_vpn,
  input  logic [ASID_W-1:0] look_asid,
  output logic              hit,
  output logic              hit_v,
  output logic              hit_d,
  output logic [2:0]        hit_c,
  output logic [PFN_W-1:0]  hit_pfn,
  input  logic              wr_en,
  input  logic [19:0]       wr_vpn,
  input  logic [ASID_W-1:0] wr_asid,
  input  logic              wr_g,
  input  logic [PFN_W-1:0]  wr_pfn,
  input  logic [2:0]        wr_c,
  input  logic              wr_d,
  input  logic              wr_v
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic              ent_valid [N];
  logic [19:0]       ent_vpn   [N];
  logic [ASID_W-1:0] ent_asid  [N];
  logic              ent_g     [N];
  logic [PFN_W-1:0]  ent_pfn   [N];
  logic [2:0]        ent_c     [N];
  logic              ent_d     [N];
  logic              ent_v     [N];
  logic [IDX_W-1:0]  ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
      for (int i = 0; i < N; i++) begin
        ent_valid[i] <= 1'b0;
        ent_vpn[i]   <= '0;
        ent_asid[i]  <= '0;
        ent_g[i]     <= 1'b0;
        ent_pfn[i]   <= '0;
        ent_c[i]     <= '0;
        ent_d[i]     <= 1'b0;
        ent_v[i]     <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < N; i++) ent_valid[i] <= 1'b0;
    end else if (wr_en) begin
      ent_valid[ptr] <= 1'b1;
      ent_vpn[ptr]   <= wr_vpn;
      ent_asid[ptr]  <= wr_asid;
      ent_g[ptr]     <= wr_g;
      ent_pfn[ptr]   <= wr_pfn;
      ent_c[ptr]     <= wr_c;
      ent_d[ptr]     <= wr_d;
      ent_v[ptr]     <= wr_v;
      ptr            <= ptr + 1'b1;
    end
  end

  // Refill only follows a miss, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_v   = 1'b0;
    hit_d   = 1'b0;
    hit_c   = '0;
    hit_pfn = '0;
    for (int i = 0; i < N; i++) begin
      if (ent_valid[i] && ent_vpn[i] == look_vpn &&
          (ent_g[i] || ent_asid[i] == look_asid)) begin
        hit     = 1'b1;
        hit_v   = ent_v[i];
        hit_d   = ent_d[i];
        hit_c   = ent_c[i];
        hit_pfn = ent_pfn[i];
      end
    end
  end

endmodule

// File: rtl/dtlb_pipe.sv
// Data-side address translation pipe: unmapped kseg0/kseg1 bypass, micro-TLB
// lookup and main-TLB refill behind request/response handshakes.
//   state     | meaning
//   ST_IDLE   | ready for a request
//   ST_LOOK   | segment decode and micro-TLB lookup
//   ST_REFILL | waiting for main-TLB ack
//   ST_RESP   | response held until accepted
module dtlb_pipe
  import tlb_pkg::*;
#(
  parameter int UTLB_N      = 4,
  parameter int ASID_W      = 8,
  parameter int PFN_W       = 20,
  parameter bit K0_UNCACHED = 1'b0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_vaddr,
  input  logic                req_rd,
  input  logic                req_wr,
  input  logic [ASID_W-1:0]   cur_asid,
  input  logic                flush,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [PFN_W+11:0]   resp_paddr,
  output logic                resp_uncache,
  output logic [EXC_W-1:0]    resp_exc,
  output logic                mtlb_req,
  input  logic                mtlb_ack,
  output logic [19:0]         mtlb_vpn,
  output logic [ASID_W-1:0]   mtlb_asid,
  input  logic                mtlb_found,
  input  logic                mtlb_g,
  input  logic                mtlb_v,
  input  logic                mtlb_d,
  input  logic [2:0]          mtlb_c,
  input  logic [PFN_W-1:0]    mtlb_pfn
);

  localparam int PA_W = PFN_W + 12;

  state_t            state, state_nxt;
  logic [31:0]       vaddr_q;
  logic              rd_q, wr_q;
  logic [ASID_W-1:0] asid_q;
  logic              unmapped, cam_wr;
  logic              hit, hit_v, hit_d;
  logic [2:0]        hit_c;
  logic [PFN_W-1:0]  hit_pfn;
  logic [PA_W-1:0]   pa_unm;

  assign unmapped  = (vaddr_q[31:29] == KSEG0) || (vaddr_q[31:29] == KSEG1);
  assign mtlb_vpn  = vaddr_q[31:12];
  assign mtlb_asid = asid_q;

  always_comb begin
    pa_unm       = '0;
    pa_unm[28:0] = vaddr_q[28:0];
  end

  utlb_cam #(.N(UTLB_N), .ASID_W(ASID_W), .PFN_W(PFN_W)) u_cam (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .look_vpn  (vaddr_q[31:12]),
    .look_asid (asid_q),
    .hit       (hit),
    .hit_v     (hit_v),
    .hit_d     (hit_d),
    .hit_c     (hit_c),
    .hit_pfn   (hit_pfn),
    .wr_en     (cam_wr),
    .wr_vpn    (vaddr_q[31:12]),
    .wr_asid   (asid_q),
    .wr_g      (mtlb_g),
    .wr_pfn    (mtlb_pfn),
    .wr_c      (mtlb_c),
    .wr_d      (mtlb_d),
    .wr_v      (mtlb_v)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = ST_LOOK;
      ST_LOOK:   state_nxt = (unmapped || hit) ? ST_RESP : ST_REFILL;
      ST_REFILL: if (mtlb_ack) state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is gated by resetn so nothing is accepted while reset is held.
  always_comb begin
    req_ready  = (state == ST_IDLE) && resetn;
    resp_valid = (state == ST_RESP);
    mtlb_req   = (state == ST_REFILL);
    cam_wr     = (state == ST_REFILL) && mtlb_ack && mtlb_found && !flush;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vaddr_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      asid_q       <= '0;
      resp_paddr   <= '0;
      resp_uncache <= 1'b0;
      resp_exc     <= '0;
    end else begin
      if (req_valid && req_ready) begin
        vaddr_q <= req_vaddr;
        rd_q    <= req_rd;
        wr_q    <= req_wr;
        asid_q  <= cur_asid;
      end
      if (state == ST_LOOK) begin
        if (unmapped) begin
          resp_paddr   <= pa_unm;
          resp_uncache <= (vaddr_q[31:29] == KSEG1) ? 1'b1 : K0_UNCACHED;
          resp_exc     <= '0;
        end else if (hit) begin
          resp_paddr   <= {hit_pfn, vaddr_q[11:0]};
          resp_uncache <= (hit_c == C_UNCACHED);
          resp_exc     <= map_exc(1'b1, hit_v, hit_d, rd_q, wr_q);
        end
      end
      if (state == ST_REFILL && mtlb_ack) begin
        resp_paddr   <= {mtlb_pfn, vaddr_q[11:0]};
        resp_uncache <= (mtlb_c == C_UNCACHED);
        resp_exc     <= map_exc(mtlb_found, mtlb_v, mtlb_d, rd_q, wr_q);
      end
    end
  end

endmodule

// File: tb/tb_dtlb_pipe.sv
// Directed bench for dtlb_pipe: unmapped segments, miss/hit, exceptions,
// round-robin eviction, flush, response back-pressure and reset mid-refill.
module tb_dtlb_pipe;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_vaddr = '0;
  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [7:0]  cur_asid = '0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_paddr;
  logic        resp_uncache;
  logic [4:0]  resp_exc;
  logic        mtlb_req, mtlb_ack = 1'b0;
  logic [19:0] mtlb_vpn;
  logic [7:0]  mtlb_asid;
  logic        mtlb_found = 1'b0, mtlb_g = 1'b0, mtlb_v = 1'b0, mtlb_d = 1'b0;
  logic [2:0]  mtlb_c = '0;
  logic [19:0] mtlb_pfn = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dtlb_pipe dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_rd(req_rd), .req_wr(req_wr), .cur_asid(cur_asid), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_uncache(resp_uncache), .resp_exc(resp_exc),
    .mtlb_req(mtlb_req), .mtlb_ack(mtlb_ack), .mtlb_vpn(mtlb_vpn), .mtlb_asid(mtlb_asid),
    .mtlb_found(mtlb_found), .mtlb_g(mtlb_g), .mtlb_v(mtlb_v), .mtlb_d(mtlb_d),
    .mtlb_c(mtlb_c), .mtlb_pfn(mtlb_pfn)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; the main TLB answers immediately with the given fields.
  task automatic access(input logic [31:0] va, input logic rd, input logic wr,
                        input logic [7:0] asid, input logic fnd, input logic g,
                        input logic v, input logic d, input logic [2:0] c,
                        input logic [19:0] pfn, input logic fl, input int hold,
                        output logic [31:0] pa, output logic unc, output logic [4:0] exc,
                        output logic missed, output logic [19:0] vpn, output int lat);
    logic got;
    got = 1'b0; missed = 1'b0; lat = 0; vpn = '0;
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = va; req_rd = rd; req_wr = wr; cur_asid = asid;
    @(posedge clk); #1;
    req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
      else begin
        if (mtlb_req) begin
          missed = 1'b1; vpn = mtlb_vpn;
          mtlb_ack = 1'b1; mtlb_found = fnd; mtlb_g = g; mtlb_v = v; mtlb_d = d;
          mtlb_c = c; mtlb_pfn = pfn; flush = fl;
        end
        @(posedge clk); lat++; #1;
        mtlb_ack = 1'b0; flush = 1'b0;
      end
    end
    chk("resp_timeout", got, 1);
    pa = resp_paddr; unc = resp_uncache; exc = resp_exc;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_paddr", resp_paddr, pa);
      chk("hold_exc", resp_exc, exc);
      chk("hold_req_ready", req_ready, 0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  logic [31:0] pa;
  logic        unc, missed;
  logic [4:0]  exc;
  logic [19:0] vpn;
  int          lat, n;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mtlb_req", mtlb_req, 0);
    chk("rst_paddr", resp_paddr, 0);
    chk("rst_unc", resp_uncache, 0);
    chk("rst_exc", resp_exc, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_ready", req_ready, 1);

    // kseg0 / kseg1 bypass
    access(32'h9FC0_0010, 1, 0, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("k0_pa", pa, 32'h1FC0_0010); chk("k0_unc", unc, 0); chk("k0_exc", exc, 0);
    chk("k0_lat", lat, 1); chk("k0_mtlb", missed, 0);
    access(32'hBFC0_0000, 0, 1, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("k1_pa", pa, 32'h1FC0_0000); chk("k1_unc", unc, 1); chk("k1_exc", exc, 0);
    chk("k1_mtlb", missed, 0);

    // miss with clean page on store -> modified, then cached hits
    access(32'h0040_1234, 0, 1, 8'd5, 1, 0, 1, 0, 3'd3, 20'h12345, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("mod_missed", missed, 1); chk("mod_vpn", vpn, 20'h00401);
    chk("mod_exc", exc, 5'b10000); chk("mod_pa", pa, 32'h1234_5234);
    chk("mod_unc", unc, 0); chk("mod_lat", lat, 2);
    access(32'h0040_1234, 1, 0, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("hit_missed", missed, 0); chk("hit_exc", exc, 0); chk("hit_pa", pa, 32'h1234_5234);
    chk("hit_lat", lat, 1);
    access(32'h0040_1238, 0, 1, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("hitmod_missed", missed, 0); chk("hitmod_exc", exc, 5'b10000);

    // other ASID, non-global entry must miss; uncached attribute
    access(32'h0040_1000, 1, 0, 8'd6, 1, 0, 1, 1, 3'd2, 20'h0AAAA, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("asid_missed", missed, 1); chk("asid_unc", unc, 1); chk("asid_pa", pa, 32'h0AAA_A000);

    // not-found pages are not cached
    access(32'h0080_0004, 1, 0, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("rdref_exc", exc, 5'b00001); chk("rdref_missed", missed, 1);
    access(32'h0080_0004, 0, 1, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("wrref_exc", exc, 5'b00010); chk("wrref_missed", missed, 1);

    // invalid page cached, re-raises on hit
    access(32'h00C0_0000, 1, 0, 8'd5, 1, 0, 0, 1, 3'd3, 20'h00333, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("rdinv_exc", exc, 5'b00100); chk("rdinv_missed", missed, 1);
    access(32'h00C0_0000, 0, 1, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("wrinv_exc", exc, 5'b01000); chk("wrinv_missed", missed, 0);

    // flush while idle drops cached translations
    do_flush();
    access(32'h0040_1234, 1, 0, 8'd5, 1, 0, 1, 1, 3'd3, 20'h12345, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("postflush_missed", missed, 1);

    // round robin: five pages into four entries evict the oldest
    do_flush();
    for (int i = 0; i < 5; i++) begin
      access(32'h0100_0000 + (i << 12), 1, 0, 8'd5, 1, 0, 1, 1, 3'd3, 20'h00100 + 20'(i), 0, 0,
             pa, unc, exc, missed, vpn, lat);
      chk("rr_fill_missed", missed, 1);
    end
    chk("rr_p4_pa", pa, 32'h0010_4000);
    access(32'h0100_1010, 1, 0, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("rr_p1_hit", missed, 0); chk("rr_p1_pa", pa, 32'h0010_1010);
    access(32'h0100_0000, 1, 0, 8'd5, 1, 0, 1, 1, 3'd3, 20'h00100, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("rr_p0_evicted", missed, 1);

    // global entry hits under another ASID
    access(32'h0300_0000, 1, 0, 8'd5, 1, 1, 1, 1, 3'd3, 20'h00777, 0, 0, pa, unc, exc, missed, vpn, lat);
    access(32'h0300_0044, 1, 0, 8'd9, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("g_hit", missed, 0); chk("g_pa", pa, 32'h0077_7044);

    // flush coincident with refill ack: result returned, not cached
    access(32'h0200_0008, 1, 0, 8'd5, 1, 0, 1, 1, 3'd3, 20'h00200, 1, 0, pa, unc, exc, missed, vpn, lat);
    chk("flack_missed", missed, 1); chk("flack_pa", pa, 32'h0020_0008); chk("flack_exc", exc, 0);
    access(32'h0200_0008, 1, 0, 8'd5, 1, 0, 1, 1, 3'd3, 20'h00200, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("flack_again_missed", missed, 1);
    access(32'h0200_0008, 1, 0, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("flack_third_hit", missed, 0);

    // back-pressure on the response
    access(32'h8000_0100, 1, 0, 8'd5, 0, 0, 0, 0, 3'd0, 20'h0, 0, 3, pa, unc, exc, missed, vpn, lat);
    chk("bp_pa", pa, 32'h0000_0100);

    // reset in the middle of a refill
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = 32'h0450_0000; req_rd = 1'b1; cur_asid = 8'd5;
    @(posedge clk); #1; req_valid = 1'b0; req_rd = 1'b0;
    n = 0;
    while (!mtlb_req && n < 10) begin @(negedge clk); n++; end
    chk("rr_refill_reached", mtlb_req, 1);
    resetn = 1'b0; #1;
    chk("rstmid_mtlb_req", mtlb_req, 0);
    chk("rstmid_resp_valid", resp_valid, 0);
    chk("rstmid_req_ready", req_ready, 0);
    @(negedge clk); resetn = 1'b1;
    mtlb_ack = 1'b1; mtlb_found = 1'b1; mtlb_v = 1'b1; mtlb_d = 1'b1; mtlb_pfn = 20'h00450;
    @(posedge clk); #1; mtlb_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ready", req_ready, 1);
    chk("late_ack_resp", resp_valid, 0);
    chk("late_ack_mtlb", mtlb_req, 0);
    access(32'h0450_0000, 1, 0, 8'd5, 1, 0, 1, 1, 3'd3, 20'h00450, 0, 0, pa, unc, exc, missed, vpn, lat);
    chk("late_ack_not_cached", missed, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
